// File: rtl/covariance_stream_if.sv
// covariance_stream_if: frame configuration, sample stream and result stream
// of the covariance block. The master side drives configuration and samples;
// the slave side (the block itself) returns backpressure, result and status.
interface covariance_stream_if #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 32
);
  logic                     start;
  logic                     mode_var;
  logic                     unbiased;
  logic signed [DATA_W-1:0] mu_x;
  logic signed [DATA_W-1:0] mu_y;
  logic signed [DATA_W-1:0] in_x;
  logic signed [DATA_W-1:0] in_y;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [OUT_W-1:0]  out;
  logic                     out_valid;
  logic                     out_ready;
  logic                     busy;

  modport master (
    output start, mode_var, unbiased, mu_x, mu_y, in_x, in_y, in_valid, out_ready,
    input  in_ready, out, out_valid, busy
  );

  modport slave (
    input  start, mode_var, unbiased, mu_x, mu_y, in_x, in_y, in_valid, out_ready,
    output in_ready, out, out_valid, busy
  );
endinterface

// File: rtl/covariance_stream.sv
// covariance_stream: fixed-point covariance (or variance) of one frame of
// NUM_INPUTS sample pairs. Centered products are summed exactly, the sum is
// divided by N or N-1 with a restoring divider (one quotient bit per cycle),
// and the floored, FRAC_W-aligned quotient is saturated to OUT_W bits.
// Assumes OUT_W < ACC_W, which holds for every practical DATA_W/NUM_INPUTS.
module covariance_stream #(
  parameter int DATA_W     = 16,
  parameter int FRAC_W     = 8,
  parameter int NUM_INPUTS = 784,
  parameter int OUT_W      = 32
) (
  input  logic               clk,
  input  logic               clr,
  covariance_stream_if.slave bus
);
  localparam int ACC_W  = 2*DATA_W + 2 + $clog2(NUM_INPUTS);
  localparam int PROD_W = 2*DATA_W + 2;
  localparam int CNT_W  = $clog2(NUM_INPUTS);
  localparam int BIT_W  = $clog2(ACC_W);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_INPUTS - 1);
  localparam logic [ACC_W:0]   DIV_UNB  = (ACC_W+1)'(NUM_INPUTS - 1);
  localparam logic [ACC_W:0]   DIV_BIA  = (ACC_W+1)'(NUM_INPUTS);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, DONE} state_t;

  state_t state_q, state_d;

  logic signed [DATA_W-1:0] mu_x_q, mu_y_q;
  logic                     mode_var_q, unbiased_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [ACC_W-1:0]         quo_q;
  logic [ACC_W:0]           rem_q;
  logic                     neg_q;
  logic [BIT_W-1:0]         bit_q;
  logic signed [OUT_W-1:0]  out_q;

  // Accumulate path: exact DATA_W+1 bit deviations and their full product.
  logic signed [DATA_W-1:0] y_sel;
  logic signed [DATA_W:0]   dx, dy;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_next;
  logic [ACC_W-1:0]         acc_abs;
  logic                     xfer, last;

  assign y_sel    = mode_var_q ? bus.in_x : bus.in_y;
  assign dx       = {bus.in_x[DATA_W-1], bus.in_x} - {mu_x_q[DATA_W-1], mu_x_q};
  assign dy       = {y_sel[DATA_W-1], y_sel} - {mu_y_q[DATA_W-1], mu_y_q};
  assign prod     = dx * dy;
  assign acc_next = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign acc_abs  = acc_next[ACC_W-1] ? -acc_next : acc_next;
  assign xfer     = bus.in_valid && (state_q == ACCUM);
  assign last     = xfer && (cnt_q == LAST_CNT);

  // Divide path: one restoring step per cycle on the magnitude, sign restored
  // at the end so the quotient truncates toward zero.
  logic [ACC_W:0]           divisor;
  logic [ACC_W+1:0]         rem_shift, trial;
  logic                     q_bit;
  logic [ACC_W:0]           rem_next;
  logic [ACC_W-1:0]         quo_next;
  logic signed [ACC_W-1:0]  q_signed, q_shift;
  logic signed [OUT_W-1:0]  sat;

  assign divisor   = unbiased_q ? DIV_UNB : DIV_BIA;
  assign rem_shift = {rem_q, quo_q[ACC_W-1]};
  assign trial     = rem_shift - {1'b0, divisor};
  assign q_bit     = ~trial[ACC_W+1];
  assign rem_next  = q_bit ? trial[ACC_W:0] : rem_shift[ACC_W:0];
  assign quo_next  = {quo_q[ACC_W-2:0], q_bit};
  assign q_signed  = neg_q ? -quo_next : quo_next;
  assign q_shift   = q_signed >>> FRAC_W;
  assign sat       = (q_shift > SAT_MAX) ? SAT_MAX[OUT_W-1:0] :
                     (q_shift < SAT_MIN) ? SAT_MIN[OUT_W-1:0] :
                                           q_shift[OUT_W-1:0];

  // State register; clr wins over everything, including mid-divide.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: default assigned first so no path leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start)     state_d = ACCUM;
      ACCUM:   if (last)          state_d = DIVIDE;
      DIVIDE:  if (bit_q == '0)   state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Datapath: latch frame config, accumulate, run the divider, register result.
  always_ff @(posedge clk) begin
    if (clr) begin
      mu_x_q     <= '0;
      mu_y_q     <= '0;
      mode_var_q <= 1'b0;
      unbiased_q <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      neg_q      <= 1'b0;
      bit_q      <= '0;
      out_q      <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          mu_x_q     <= bus.mu_x;
          mu_y_q     <= bus.mu_y;
          mode_var_q <= bus.mode_var;
          unbiased_q <= bus.unbiased;
          acc_q      <= '0;
          cnt_q      <= '0;
        end
        ACCUM: if (xfer) begin
          acc_q <= acc_next;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            quo_q <= acc_abs;
            rem_q <= '0;
            neg_q <= acc_next[ACC_W-1];
            bit_q <= BIT_W'(ACC_W - 1);
          end
        end
        DIVIDE: begin
          quo_q <= quo_next;
          rem_q <= rem_next;
          bit_q <= bit_q - 1'b1;
          if (bit_q == '0) out_q <= sat;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out       = out_q;
endmodule

// File: doc/covariance_stream.md
Name: covariance_stream

Overview:
- Parametrised fixed-point successor to the float covariance pipeline in the SSIM datapath.
- Accepts a frame of NUM_INPUTS sample pairs (x, y) over a valid/ready stream, with means supplied at frame start.
- Accumulates (x-mu_x)*(y-mu_y) exactly in a wide integer accumulator, then divides by N-1 (unbiased) or N (biased) with an on-block sequential divider.
- Adds a variance mode (y := x), output backpressure and a saturating output; feeds the SSIM combine stage.

Parameters:
DATA_W, 16, width of signed x, y, mu_x, mu_y (two's complement)
FRAC_W, 8, fractional bits of all inputs and of out
NUM_INPUTS, 784, samples per frame; must be >= 2
OUT_W, 32, width of signed result
ACC_W, 2*DATA_W+2+$clog2(NUM_INPUTS), accumulator and divider width (derived, not overridden)

Ports:
clk  in  1  clock, all logic on rising edge
clr  in  1  synchronous active-high reset
start  in  1  frame start pulse; sampled only in IDLE
mode_var  in  1  1: variance (y ignored, x used for both); latched at start
unbiased  in  1  1: divisor NUM_INPUTS-1, 0: NUM_INPUTS; latched at start
mu_x  in  DATA_W  mean of x; latched at start
mu_y  in  DATA_W  mean of y; latched at start
in_x  in  DATA_W  sample x
in_y  in  DATA_W  sample y
in_valid  in  1  sample pair valid
in_ready  out  1  block accepts sample pair
out  out  OUT_W  covariance/variance result, FRAC_W fractional bits
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
busy  out  1  high in any state except IDLE

Behaviour:
- Reset: clr is synchronous and active-high. It has priority over all other inputs in any state, including mid-frame and mid-divide. Next state IDLE; out=0, out_valid=0, in_ready=0, busy=0; accumulator and sample count cleared.
- States:
  - IDLE: start=1 latches mu_x, mu_y, mode_var, unbiased, clears acc and count, goes to ACCUM.
  - ACCUM: in_ready=1. A transfer is in_valid&&in_ready. On each transfer:
    - dx = in_x-mu_x and dy = (mode_var ? in_x : in_y)-mu_y, each DATA_W+1 bits signed, exact.
    - acc += dx*dy, with the product sign-extended to ACC_W. No overflow is possible by construction.
    - count++.
    - The transfer with count==NUM_INPUTS-1 is the last: in_ready drops the next cycle and the state goes to DIVIDE.
  - DIVIDE: restoring division of |acc| by D (D = unbiased ? NUM_INPUTS-1 : NUM_INPUTS), one quotient bit per cycle for exactly ACC_W cycles. After the final cycle, the quotient sign is applied (quotient truncated toward zero) and the state goes to DONE.
  - DONE: out_valid=1 and out is stable until out_valid&&out_ready, then IDLE next cycle. out holds its last value in IDLE.
- Result: out = sat_OUT_W(Q >>> FRAC_W), where Q is the signed quotient and >>> is an arithmetic shift (floor). Saturation clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Latency: the last transfer occurs at edge E0. DIVIDE runs edges E1..E_ACC_W, and out_valid is high from edge E_ACC_W onward. The result is therefore visible ACC_W cycles after the last transfer; for the default parameters this is 44.
- Throughput: one sample per cycle in ACCUM; gaps in in_valid are allowed.
- start outside IDLE is ignored. start coincident with clr is ignored.
- in_valid outside ACCUM is ignored; no transfer occurs.
- Samples are neither counted nor stored while in_ready=0.
- busy is high from the cycle after start through the DONE handshake cycle.

Test Plan:
- Variance, unbiased: DATA_W=16, FRAC_W=8, NUM_INPUTS=4, mu_x=640. x = 256, 512, 768, 1024 -> acc=327680, Q=109226, out=426 (1.664). out_valid high exactly 36 cycles after the last transfer.
- Same stream with unbiased=0 -> Q=81920, out=320 (1.25).
- Covariance, anti-correlated: mode_var=0, y = 1024, 768, 512, 256, mu_x=mu_y=640 -> acc=-327680, Q=-109226, out=-427 (floor shift).
- Backpressure and gaps:
  - in_valid toggled randomly gives the same out as the contiguous stream.
  - out_ready held low for 10 cycles: out and out_valid stay stable, busy=1, and start is ignored.
  - Returns to IDLE one cycle after out_ready=1.
- Saturation: OUT_W=16, x=32767 for all 4 samples, mu_x=-32768, unbiased=0 -> out=32767. Repeat in covariance mode with y=-32768, mu_y=32767 -> out=-32768.
- Reset mid-operation:
  - clr asserted after 2 transfers, and again during DIVIDE: next cycle state is IDLE, all outputs 0.
  - A new full frame then yields the correct result, with no residue from the aborted frame.
